// File: rtl/csr_if.sv
// csr_if: CSR request/response bus between the decode stage and csr_unit.
interface csr_if;
    logic        valid;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  uimm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        illegal;
    modport master (output valid, funct3, addr, uimm, wdata, input rdata, rvalid, illegal);
    modport slave  (input valid, funct3, addr, uimm, wdata, output rdata, rvalid, illegal);
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (mstatus.MIE, mtvec, mscratch, mepc, mcause) with trap capture.
// Define CSR_COUNTER_EN to add 64-bit mcycle/minstret and their read-only aliases.
module csr_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    csr_if.slave        bus,
    input  logic        instr_retire,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_cause,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);
    logic        mie;
    logic [29:0] mtvec;
    logic [31:0] mscratch, mcause;
    logic [30:0] mepc;
    logic [31:0] op, old, nv;
    logic        impl, wr_int, legal, accept, do_wr;
    logic        unused;
`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle, minstret, cyc_inc, ret_inc;
    assign cyc_inc = mcycle + 64'd1;
    assign ret_inc = minstret + {63'd0, instr_retire};
`endif
    assign unused  = exc_pc[0] ^ instr_retire;
    assign mtvec_o = {mtvec, 2'b00};
    assign mepc_o  = {mepc, 1'b0};
    assign mie_o   = mie;
    always_comb begin
        old  = '0;
        impl = 1'b1;
        case (bus.addr)
            12'h300: old = {28'd0, mie, 3'd0};
            12'h305: old = {mtvec, 2'b00};
            12'h340: old = mscratch;
            12'h341: old = {mepc, 1'b0};
            12'h342: old = mcause;
`ifdef CSR_COUNTER_EN
            12'hB00, 12'hC00: old = mcycle[31:0];
            12'hB80, 12'hC80: old = mcycle[63:32];
            12'hB02, 12'hC02: old = minstret[31:0];
            12'hB82, 12'hC82: old = minstret[63:32];
`endif
            default: impl = 1'b0;
        endcase
        op     = bus.funct3[2] ? {27'd0, bus.uimm} : bus.wdata;
        nv     = bus.funct3[1:0] == 2'b01 ? op : bus.funct3[1:0] == 2'b10 ? old | op : old & ~op;
        wr_int = bus.funct3[1:0] == 2'b01 || bus.uimm != 5'd0;
        legal  = impl && !(wr_int && bus.addr[11:10] == 2'b11);
        accept = bus.valid && bus.funct3[1:0] != 2'b00 && !exc_valid;
        do_wr  = accept && legal && wr_int;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mie         <= 1'b0;
            mtvec       <= MTVEC_RST[31:2];
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            bus.rdata   <= '0;
            bus.rvalid  <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            bus.rvalid  <= accept && legal;
            bus.illegal <= accept && !legal;
            bus.rdata   <= accept && legal ? old : '0;
            // A trap in the same cycle drops the CSR request entirely
            if (exc_valid) begin
                mepc   <= exc_pc[31:1];
                mcause <= exc_cause;
                mie    <= 1'b0;
            end else if (do_wr) begin
                case (bus.addr)
                    12'h300: mie      <= nv[3];
                    12'h305: mtvec    <= nv[31:2];
                    12'h340: mscratch <= nv;
                    12'h341: mepc     <= nv[31:1];
                    12'h342: mcause   <= nv;
                    default: ;
                endcase
            end
        end
    end
`ifdef CSR_COUNTER_EN
    // A write to one half replaces only that half's increment; carry still reaches hi
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle[31:0]    <= do_wr && bus.addr == 12'hB00 ? nv : cyc_inc[31:0];
            mcycle[63:32]   <= do_wr && bus.addr == 12'hB80 ? nv : cyc_inc[63:32];
            minstret[31:0]  <= do_wr && bus.addr == 12'hB02 ? nv : ret_inc[31:0];
            minstret[63:32] <= do_wr && bus.addr == 12'hB82 ? nv : ret_inc[63:32];
        end
    end
`endif
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed CSR vectors with a queue-based scoreboard and an independent output monitor.
module tb_csr_unit;
    localparam logic [31:0] MTVEC_RST = 32'h8000_0100;
    typedef struct {
        int          kind;
        logic [31:0] data;
        bit          chk;
    } exp_t;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        instr_retire = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_pc = '0, exc_cause = '0;
    logic [31:0] mtvec_o, mepc_o;
    logic        mie_o;
    int          vectors = 0, errors = 0;
    exp_t        q[$];
    csr_if bus();
    csr_unit #(.MTVEC_RST(MTVEC_RST)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .instr_retire(instr_retire),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );
    always #5 clk = ~clk;
    // kind: 1 = expect rvalid with data, 2 = expect illegal pulse
    always @(negedge clk) begin
        if (bus.rvalid && bus.illegal) begin
            vectors++; errors++;
            $display("FAIL both_pulses: rvalid=%0b illegal=%0b required not both 1", bus.rvalid, bus.illegal);
        end else if (bus.rvalid || bus.illegal) begin
            exp_t e;
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious: rvalid=%0b illegal=%0b rdata=%h required no response", bus.rvalid, bus.illegal, bus.rdata);
            end else begin
                e = q.pop_front();
                if ((e.kind == 1) != bus.rvalid || (e.kind == 2) != bus.illegal || (e.chk && bus.rdata !== e.data)) begin
                    errors++;
                    $display("FAIL response: rvalid=%0b illegal=%0b rdata=%h required kind=%0d rdata=%h", bus.rvalid, bus.illegal, bus.rdata, e.kind, e.data);
                end
            end
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] u, input logic [31:0] d, input int kind, input logic [31:0] exp, input bit chk = 1'b1);
        bus.valid = 1'b1; bus.funct3 = f3; bus.addr = a; bus.uimm = u; bus.wdata = d;
        if (kind != 0) q.push_back('{kind, exp, chk});
        @(posedge clk); #1;
        bus.valid = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    initial begin
        bus.valid = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.uimm = '0; bus.wdata = '0;
        #23 n_rst = 1'b1;
        idle(2);
        check("rst_mtvec", mtvec_o, MTVEC_RST);
        check("rst_mepc", mepc_o, 32'h0);
        check("rst_mie", {31'd0, mie_o}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_pulses", {30'd0, bus.rvalid, bus.illegal}, 32'h0);
        issue(3'b010, 12'h305, 5'd0, 32'hFFFF_FFFF, 1, MTVEC_RST);
        check("mtvec_unchanged", mtvec_o, MTVEC_RST);
        issue(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 1, 32'h0);
        issue(3'b010, 12'h340, 5'd1, 32'h0000_0011, 1, 32'hDEAD_BEEF);
        issue(3'b010, 12'h340, 5'd0, 32'h0, 1, 32'hDEAD_BEFF);
        issue(3'b110, 12'h300, 5'd8, 32'h0, 1, 32'h0);
        check("mie_set", {31'd0, mie_o}, 32'h1);
        issue(3'b111, 12'h300, 5'd8, 32'h0, 1, 32'h8);
        check("mie_clr", {31'd0, mie_o}, 32'h0);
        issue(3'b001, 12'hC00, 5'd0, 32'h1, 2, 32'h0);
        issue(3'b000, 12'h340, 5'd3, 32'h0, 0, 32'h0);
        issue(3'b100, 12'h340, 5'd3, 32'h0, 0, 32'h0);
        issue(3'b010, 12'h340, 5'd0, 32'h0, 1, 32'hDEAD_BEFF);
        issue(3'b010, 12'h7C0, 5'd0, 32'h0, 2, 32'h0);
        issue(3'b001, 12'h305, 5'd0, 32'h1234_5677, 1, MTVEC_RST);
        check("mtvec_wr", mtvec_o, 32'h1234_5674);
        issue(3'b010, 12'h305, 5'd0, 32'h0, 1, 32'h1234_5674);
        issue(3'b001, 12'h300, 5'd0, 32'hFFFF_FFFF, 1, 32'h0);
        issue(3'b010, 12'h300, 5'd0, 32'h0, 1, 32'h8);
        exc_valid = 1'b1; exc_pc = 32'h103; exc_cause = 32'hB;
        issue(3'b001, 12'h341, 5'd0, 32'h5555, 0, 32'h0);
        exc_valid = 1'b0;
        check("trap_mepc", mepc_o, 32'h102);
        check("trap_mie", {31'd0, mie_o}, 32'h0);
        issue(3'b010, 12'h342, 5'd0, 32'h0, 1, 32'hB);
        issue(3'b001, 12'h341, 5'd0, 32'hFFFF_FFFF, 1, 32'h102);
        issue(3'b010, 12'h341, 5'd0, 32'h0, 1, 32'hFFFF_FFFE);
`ifdef CSR_COUNTER_EN
        issue(3'b001, 12'hB80, 5'd0, 32'h0, 1, 32'h0, 1'b0);
        issue(3'b001, 12'hB00, 5'd0, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
        idle(1);
        issue(3'b010, 12'hB80, 5'd0, 32'h0, 1, 32'h1);
        issue(3'b010, 12'hC80, 5'd0, 32'h0, 1, 32'h1);
`else
        issue(3'b010, 12'hB00, 5'd0, 32'h0, 2, 32'h0);
        issue(3'b010, 12'hC82, 5'd0, 32'h0, 2, 32'h0);
`endif
        issue(3'b110, 12'h300, 5'd8, 32'h0, 1, 32'h0);
        issue(3'b010, 12'h340, 5'd0, 32'h0, 1, 32'hDEAD_BEFF);
        bus.valid = 1'b1; bus.funct3 = 3'b001; bus.addr = 12'h340; bus.wdata = 32'h0;
        @(negedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("arst_rdata", bus.rdata, 32'h0);
        check("arst_pulses", {30'd0, bus.rvalid, bus.illegal}, 32'h0);
        check("arst_mie", {31'd0, mie_o}, 32'h0);
        check("arst_mtvec", mtvec_o, MTVEC_RST);
        check("arst_mepc", mepc_o, 32'h0);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        #2 n_rst = 1'b1;
        idle(3);
        issue(3'b010, 12'h340, 5'd0, 32'h0, 1, 32'h0);
        idle(3);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
